twofish_seq_counters: RTL

Round and key-schedule counter unit for the Twofish core; it is the counter side of the `controller` handshake. It consumes the controller's `srst`/`sce` and `krst`/`kce` commands and returns the `szero`/`kzero` completion flags. It also generates the subkey-pair write index used during key expansion and the subkey-pair read address used during the 16 rounds.

---
 rtl/twofish_pkg.sv | 11 +
 rtl/sat_down_counter.sv | 29 ++
 rtl/twofish_seq_counters.sv | 67 ++++++
 3 files changed

// File: rtl/twofish_pkg.sv
// Shared constants for the Twofish round/key-schedule counter slice.
package twofish_pkg;
  localparam int ROUNDS          = 16;
  localparam int KPAIRS          = 20;
  localparam int CNT_W           = 5;
  localparam int RIDX_W          = 4;
  localparam int KADDR_W         = 5;
  localparam int WHITEN_IN_BASE  = 0;
  localparam int WHITEN_OUT_BASE = 2;
  localparam int ROUND_KEY_BASE  = 4;
endpackage

// File: rtl/sat_down_counter.sv
// Loadable down-counter that saturates at zero instead of wrapping.
module sat_down_counter #(
  parameter int W    = 5,
  parameter int LOAD = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  output logic         zero,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;

  // Load wins over enable; enable at zero is ignored.
  always_comb begin
    cnt_d = cnt_q;
    if (load)                   cnt_d = W'(LOAD);
    else if (en && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);
endmodule

// File: rtl/twofish_seq_counters.sv
// Round and key-schedule counters for the Twofish controller handshake.
// Optional TWOFISH_DECRYPT_EN adds a decrypt input that reverses round-key order.
module twofish_seq_counters #(
  parameter int ROUNDS = twofish_pkg::ROUNDS,
  parameter int KPAIRS = twofish_pkg::KPAIRS
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             srst,
  input  logic                             sce,
  input  logic                             krst,
  input  logic                             kce,
`ifdef TWOFISH_DECRYPT_EN
  input  logic                             decrypt,
`endif
  output logic                             szero,
  output logic                             kzero,
  output logic [twofish_pkg::RIDX_W-1:0]   round_idx,
  output logic [twofish_pkg::KADDR_W-1:0]  rk_addr,
  output logic [twofish_pkg::KADDR_W-1:0]  key_idx,
  output logic                             key_we,
  output logic                             round_done
);
  import twofish_pkg::*;

  logic [CNT_W-1:0] rcnt, kcnt;
  logic             round_done_q, round_done_d;

  sat_down_counter #(.W(CNT_W), .LOAD(ROUNDS)) u_rcnt (
    .clk(clk), .reset(reset), .load(srst), .en(sce), .zero(szero), .cnt(rcnt)
  );

  sat_down_counter #(.W(CNT_W), .LOAD(KPAIRS)) u_kcnt (
    .clk(clk), .reset(reset), .load(krst), .en(kce), .zero(kzero), .cnt(kcnt)
  );

  // At rcnt==0 the difference is ROUNDS, which truncates back to round 0.
  assign round_idx = RIDX_W'(CNT_W'(ROUNDS) - rcnt);
  assign key_idx   = kzero ? '0 : KADDR_W'(CNT_W'(KPAIRS) - kcnt);
  assign key_we    = kce && !krst && !kzero;

  // Pulse only on a genuine 1->0 step; a coincident reload cancels it.
  assign round_done_d = sce && !srst && (rcnt == CNT_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) round_done_q <= 1'b0;
    else        round_done_q <= round_done_d;
  end

  assign round_done = round_done_q;

`ifdef TWOFISH_DECRYPT_EN
  logic mode_q, mode_d;

  assign mode_d = srst ? decrypt : mode_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mode_q <= 1'b0;
    else        mode_q <= mode_d;
  end

  assign rk_addr = mode_q ? KADDR_W'(ROUND_KEY_BASE + ROUNDS - 1) - KADDR_W'(round_idx)
                          : KADDR_W'(ROUND_KEY_BASE) + KADDR_W'(round_idx);
`else
  assign rk_addr = KADDR_W'(ROUND_KEY_BASE) + KADDR_W'(round_idx);
`endif
endmodule
